pixel_fetch_unit: RTL and testbench

PIXEL_FETCH_UNIT -- requirements
Module: pixel_fetch_unit

---
 rtl/pixel_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_pixel_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_unit.sv
// Pixel fetch unit: scans a frame, issues one SDRAM read per pixel and writes returned words to the frame buffer.
// Optional feature macro PIXEL_FETCH_SKIP_ZERO_EN: pixels whose address is 0 are written as 0 without a read.
module pixel_fetch_unit #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int MAX_OUT = 4
) (
    input  logic        clk_50,
    input  logic        Reset_n,
    input  logic        frame_start,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    input  logic [24:0] Address,
    output logic        sdram_read,
    output logic [24:0] sdram_address,
    input  logic        sdram_waitrequest,
    input  logic [15:0] sdram_readdata,
    input  logic        sdram_readdatavalid,
    output logic        fb_write,
    output logic [18:0] fb_address,
    output logic [15:0] fb_data,
    output logic        busy,
    output logic        frame_done
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUT);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUT - 1);
    localparam logic [9:0]    X_LAST   = 10'(H_RES - 1);
    localparam logic [9:0]    Y_LAST   = 10'(V_RES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, STALL, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          first_q, first_d;
    logic [24:0]   addr_q;
    logic [18:0]   tag_mem_q [MAX_OUT];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          fb_write_q;
    logic [18:0]   fb_addr_q;
    logic [15:0]   fb_data_q;

    logic [18:0]   pix_addr, skip_addr;
    logic          in_issue, hold_skip, zero_addr, skip_take, skip_fire, skip_pend;
    logic          accept, take, push, pop, last_pix;

    assign pix_addr  = 19'(y_q) * 19'(H_RES) + 19'(x_q);
    assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign in_issue  = (state_q == ISSUE);
    assign skip_take = zero_addr && !hold_skip;
    assign pop       = sdram_readdatavalid && (count_q != '0);

`ifdef PIXEL_FETCH_SKIP_ZERO_EN
    logic        skip_valid_q, skip_valid_d;
    logic [18:0] skip_addr_q, skip_addr_d;

    assign hold_skip = in_issue && first_q && skip_valid_q;
    assign zero_addr = in_issue && first_q && (Address == '0);
    assign skip_fire = skip_valid_q && !pop;
    assign skip_addr = skip_addr_q;
    assign skip_pend = skip_valid_q;

    always_comb begin
        skip_valid_d = skip_valid_q;
        skip_addr_d  = skip_addr_q;
        if (skip_fire) skip_valid_d = 1'b0;
        if (skip_take) begin
            skip_valid_d = 1'b1;
            skip_addr_d  = pix_addr;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!Reset_n) begin
            skip_valid_q <= 1'b0;
            skip_addr_q  <= '0;
        end else begin
            skip_valid_q <= skip_valid_d;
            skip_addr_q  <= skip_addr_d;
        end
    end
`else
    assign hold_skip = 1'b0;
    assign zero_addr = 1'b0;
    assign skip_fire = 1'b0;
    assign skip_addr = '0;
    assign skip_pend = 1'b0;
`endif

    // The selector output is only valid in the first ISSUE cycle, so it is passed straight through then and held after.
    assign sdram_read    = in_issue && !hold_skip && !zero_addr;
    assign sdram_address = (in_issue && first_q) ? Address : addr_q;
    assign accept        = sdram_read && !sdram_waitrequest;
    assign push          = accept;
    assign take          = accept || skip_take;
    assign count_d       = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: if (frame_start) begin
                x_d     = '0;
                y_d     = '0;
                state_d = SETUP;
            end
            SETUP: begin
                state_d = ISSUE;
                first_d = 1'b1;
            end
            ISSUE: if (take) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
                end else begin
                    x_d = x_q + 10'd1;
                end
                if (last_pix)             state_d = DRAIN;
                else if (count_d < MAX_C) state_d = SETUP;
                else                      state_d = STALL;
            end else begin
                first_d = first_q && hold_skip;
            end
            STALL: if (count_d < MAX_C) state_d = SETUP;
            DRAIN: if (count_q == '0 && !skip_pend) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            first_q    <= 1'b0;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fb_write_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            first_q <= first_d;
            count_q <= count_d;
            if (in_issue && first_q) addr_q <= Address;
            if (push) begin
                tag_mem_q[wr_ptr_q] <= pix_addr;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            fb_write_q <= pop || skip_fire;
            if (pop) begin
                fb_addr_q <= tag_mem_q[rd_ptr_q];
                fb_data_q <= sdram_readdata;
            end else if (skip_fire) begin
                fb_addr_q <= skip_addr;
                fb_data_q <= '0;
            end
        end
    end

    assign DrawX      = x_q;
    assign DrawY      = y_q;
    assign fb_write   = fb_write_q;
    assign fb_address = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_pixel_fetch_unit.sv
// Directed bench for pixel_fetch_unit on a 4x2 frame with a registered address selector and an in-order SDRAM model.
module tb_pixel_fetch_unit;
    localparam int H = 4;
    localparam int V = 2;
    localparam int NPIX = 8;

    logic        clk_50 = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX, DrawY;
    logic [24:0] Address = '0;
    logic        sdram_read;
    logic [24:0] sdram_address;
    logic        sdram_waitrequest = 1'b0;
    logic [15:0] sdram_readdata = '0;
    logic        sdram_readdatavalid = 1'b0;
    logic        fb_write;
    logic [18:0] fb_address;
    logic [15:0] fb_data;
    logic        busy, frame_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_count, wr_count, fd_count, oob_count, zero_reads;
    int seen [NPIX];
    int wcyc [NPIX];
    logic [15:0] wdata [NPIX];
    int resp_budget = -1;
    bit zero_pix3 = 1'b0;
    logic [24:0] q_addr [$];
    int q_rdy [$];
    logic [24:0] sel_nxt;
    logic [24:0] resp_a;

    pixel_fetch_unit #(.H_RES(H), .V_RES(V), .MAX_OUT(4)) dut (
        .clk_50(clk_50), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .Address(Address),
        .sdram_read(sdram_read), .sdram_address(sdram_address),
        .sdram_waitrequest(sdram_waitrequest), .sdram_readdata(sdram_readdata),
        .sdram_readdatavalid(sdram_readdatavalid),
        .fb_write(fb_write), .fb_address(fb_address), .fb_data(fb_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk_50 = ~clk_50;

    // Registered address selector: pixel (x,y) maps to word y*4+x+100, one cycle after DrawX/DrawY change.
    initial forever begin
        @(negedge clk_50);
        sel_nxt = (zero_pix3 && DrawY == 10'd0 && DrawX == 10'd3) ? 25'd0 : 25'(DrawY * H + DrawX + 100);
        @(posedge clk_50);
        #1 Address = sel_nxt;
    end

    // SDRAM model (data = address + 0x1000, 2-cycle latency) and frame-buffer monitor.
    initial forever begin
        @(negedge clk_50);
        #2;
        cyc++;
        sdram_readdatavalid = 1'b0;
        if (q_addr.size() > 0 && q_rdy[0] <= cyc && resp_budget != 0) begin
            resp_a = q_addr.pop_front();
            void'(q_rdy.pop_front());
            sdram_readdatavalid = 1'b1;
            sdram_readdata = resp_a[15:0] + 16'h1000;
            if (resp_budget > 0) resp_budget--;
        end
        if (sdram_read && !sdram_waitrequest) begin
            acc_count++;
            if (sdram_address == '0) zero_reads++;
            q_addr.push_back(sdram_address);
            q_rdy.push_back(cyc + 2);
        end
        if (fb_write) begin
            wr_count++;
            if (fb_address < NPIX) begin
                seen[fb_address]++;
                wdata[fb_address] = fb_data;
                wcyc[fb_address] = cyc;
            end else oob_count++;
        end
        if (frame_done) fd_count++;
    end

    task automatic clear_counts();
        acc_count = 0; wr_count = 0; fd_count = 0; oob_count = 0; zero_reads = 0;
        for (int i = 0; i < NPIX; i++) begin
            seen[i] = 0; wdata[i] = '0; wcyc[i] = 0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_50) frame_start = 1'b1;
        @(negedge clk_50) frame_start = 1'b0;
    endtask

    task automatic test_reset();
        clear_counts();
        Reset_n = 1'b0;
        repeat (2) @(negedge clk_50);
        total++; if (DrawX !== 10'd0) begin bad++; $display("FAIL reset_drawx got=%0d want=0", DrawX); end
        total++; if (DrawY !== 10'd0) begin bad++; $display("FAIL reset_drawy got=%0d want=0", DrawY); end
        total++; if (sdram_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%0b want=0", sdram_read); end
        total++; if (sdram_address !== 25'd0) begin bad++; $display("FAIL reset_saddr got=%0h want=0", sdram_address); end
        total++; if ({fb_write, fb_address, fb_data} !== 36'd0) begin bad++; $display("FAIL reset_fb got=%0h want=0", {fb_write, fb_address, fb_data}); end
        total++; if ({busy, frame_done} !== 2'b00) begin bad++; $display("FAIL reset_status got=%0b want=00", {busy, frame_done}); end
        Reset_n = 1'b1;
        @(negedge clk_50);
    endtask

    task automatic test_frame();
        clear_counts();
        sdram_waitrequest = 1'b0;
        resp_budget = -1;
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_busy_start got=%0b want=1", busy); end
        repeat (3) @(negedge clk_50);
        frame_start = 1'b1;
        @(negedge clk_50) frame_start = 1'b0;
        for (int i = 0; i < 300 && fd_count == 0; i++) @(negedge clk_50);
        total++; if (fd_count == 0) begin bad++; $display("FAIL frame_timeout got=%0d want=1", fd_count); end
        repeat (5) @(negedge clk_50);
        total++; if (fd_count !== 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", fd_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_end got=%0b want=0", busy); end
        total++; if (wr_count !== 8) begin bad++; $display("FAIL frame_writes got=%0d want=8", wr_count); end
        total++; if (acc_count !== 8) begin bad++; $display("FAIL frame_reads got=%0d want=8", acc_count); end
        total++; if (oob_count !== 0) begin bad++; $display("FAIL frame_oob got=%0d want=0", oob_count); end
        for (int i = 0; i < NPIX; i++) begin
            total++; if (seen[i] !== 1) begin bad++; $display("FAIL frame_seen[%0d] got=%0d want=1", i, seen[i]); end
            total++; if (wdata[i] !== 16'h1064 + 16'(i)) begin bad++; $display("FAIL frame_data[%0d] got=%0h want=%0h", i, wdata[i], 16'h1064 + 16'(i)); end
        end
    endtask

    task automatic test_waitrequest();
        int n;
        clear_counts();
        sdram_waitrequest = 1'b1;
        pulse_start();
        for (n = 0; n < 20 && !sdram_read; n++) @(negedge clk_50);
        total++; if (sdram_read !== 1'b1) begin bad++; $display("FAIL wait_first_read got=%0b want=1", sdram_read); end
        sdram_waitrequest = 1'b0;
        @(negedge clk_50) sdram_waitrequest = 1'b1;
        for (n = 0; n < 20 && !sdram_read; n++) @(negedge clk_50);
        for (int k = 0; k < 5; k++) begin
            total++; if (sdram_read !== 1'b1) begin bad++; $display("FAIL wait_read[%0d] got=%0b want=1", k, sdram_read); end
            total++; if (sdram_address !== 25'd101) begin bad++; $display("FAIL wait_addr[%0d] got=%0d want=101", k, sdram_address); end
            total++; if (DrawX !== 10'd1) begin bad++; $display("FAIL wait_drawx[%0d] got=%0d want=1", k, DrawX); end
            total++; if (acc_count !== 1) begin bad++; $display("FAIL wait_accepts[%0d] got=%0d want=1", k, acc_count); end
            @(negedge clk_50);
        end
        sdram_waitrequest = 1'b0;
        for (int i = 0; i < 300 && fd_count == 0; i++) @(negedge clk_50);
        repeat (3) @(negedge clk_50);
        total++; if (fd_count !== 1) begin bad++; $display("FAIL wait_done got=%0d want=1", fd_count); end
        total++; if (wr_count !== 8) begin bad++; $display("FAIL wait_writes got=%0d want=8", wr_count); end
        total++; if (seen[1] !== 1) begin bad++; $display("FAIL wait_seen1 got=%0d want=1", seen[1]); end
    endtask

    task automatic test_stall();
        clear_counts();
        resp_budget = 0;
        pulse_start();
        repeat (40) @(negedge clk_50);
        total++; if (acc_count !== 4) begin bad++; $display("FAIL stall_accepts got=%0d want=4", acc_count); end
        total++; if (sdram_read !== 1'b0) begin bad++; $display("FAIL stall_read got=%0b want=0", sdram_read); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%0b want=1", busy); end
        total++; if ({DrawY, DrawX} !== {10'd1, 10'd0}) begin bad++; $display("FAIL stall_pos got=%0d,%0d want=1,0", DrawY, DrawX); end
        total++; if (wr_count !== 0) begin bad++; $display("FAIL stall_writes got=%0d want=0", wr_count); end
        resp_budget = 1;
        repeat (20) @(negedge clk_50);
        total++; if (acc_count !== 5) begin bad++; $display("FAIL stall_one_more got=%0d want=5", acc_count); end
        total++; if (wr_count !== 1) begin bad++; $display("FAIL stall_one_write got=%0d want=1", wr_count); end
        total++; if (wdata[0] !== 16'h1064) begin bad++; $display("FAIL stall_data0 got=%0h want=1064", wdata[0]); end
        resp_budget = -1;
        for (int i = 0; i < 300 && fd_count == 0; i++) @(negedge clk_50);
        repeat (3) @(negedge clk_50);
        total++; if (fd_count !== 1) begin bad++; $display("FAIL stall_done got=%0d want=1", fd_count); end
        total++; if (wr_count !== 8) begin bad++; $display("FAIL stall_writes_end got=%0d want=8", wr_count); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        resp_budget = 0;
        pulse_start();
        for (int i = 0; i < 40 && acc_count < 3; i++) @(negedge clk_50);
        total++; if (acc_count !== 3) begin bad++; $display("FAIL rmid_outstanding got=%0d want=3", acc_count); end
        Reset_n = 1'b0;
        @(negedge clk_50) Reset_n = 1'b1;
        total++; if ({DrawX, DrawY, sdram_read, sdram_address} !== 46'd0) begin bad++; $display("FAIL rmid_fetch_outs got=%0h want=0", {DrawX, DrawY, sdram_read, sdram_address}); end
        total++; if ({fb_write, fb_address, fb_data, busy, frame_done} !== 38'd0) begin bad++; $display("FAIL rmid_fb_outs got=%0h want=0", {fb_write, fb_address, fb_data, busy, frame_done}); end
        resp_budget = -1;
        repeat (10) @(negedge clk_50);
        total++; if (wr_count !== 0) begin bad++; $display("FAIL rmid_late_writes got=%0d want=0", wr_count); end
        total++; if (fd_count !== 0) begin bad++; $display("FAIL rmid_frame_done got=%0d want=0", fd_count); end
        total++; if (q_addr.size() !== 0) begin bad++; $display("FAIL rmid_late_resp got=%0d want=0", q_addr.size()); end
        clear_counts();
        pulse_start();
        for (int i = 0; i < 300 && fd_count == 0; i++) @(negedge clk_50);
        repeat (3) @(negedge clk_50);
        total++; if (fd_count !== 1) begin bad++; $display("FAIL rmid_new_done got=%0d want=1", fd_count); end
        total++; if (wr_count !== 8) begin bad++; $display("FAIL rmid_new_writes got=%0d want=8", wr_count); end
        for (int i = 0; i < NPIX; i++) begin
            total++; if (seen[i] !== 1) begin bad++; $display("FAIL rmid_seen[%0d] got=%0d want=1", i, seen[i]); end
        end
    endtask

`ifdef PIXEL_FETCH_SKIP_ZERO_EN
    task automatic test_skip_zero();
        clear_counts();
        zero_pix3 = 1'b1;
        resp_budget = -1;
        pulse_start();
        for (int i = 0; i < 300 && fd_count == 0; i++) @(negedge clk_50);
        repeat (3) @(negedge clk_50);
        zero_pix3 = 1'b0;
        total++; if (fd_count !== 1) begin bad++; $display("FAIL skip_done got=%0d want=1", fd_count); end
        total++; if (acc_count !== 7) begin bad++; $display("FAIL skip_reads got=%0d want=7", acc_count); end
        total++; if (zero_reads !== 0) begin bad++; $display("FAIL skip_zero_reads got=%0d want=0", zero_reads); end
        total++; if (wr_count !== 8) begin bad++; $display("FAIL skip_writes got=%0d want=8", wr_count); end
        total++; if (wdata[3] !== 16'h0000) begin bad++; $display("FAIL skip_data3 got=%0h want=0", wdata[3]); end
        total++; if (wcyc[3] !== wcyc[2] + 1) begin bad++; $display("FAIL skip_order got=%0d want=%0d", wcyc[3], wcyc[2] + 1); end
        for (int i = 0; i < NPIX; i++) begin
            total++; if (seen[i] !== 1) begin bad++; $display("FAIL skip_seen[%0d] got=%0d want=1", i, seen[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_waitrequest();
        test_stall();
        test_reset_mid();
`ifdef PIXEL_FETCH_SKIP_ZERO_EN
        test_skip_zero();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
